add_seq: RTL

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/alu_pkg.sv | 22 ++
 rtl/add_chunk.sv | 23 ++
 rtl/add_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encodings and flag-bit positions.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   // Bit positions of the zero/negative/carry/overflow flags in a packed flag word
   localparam int unsigned FLAG_V = 0;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned NFLAGS = 4;

   // Counter width able to index n items, never less than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice with carry out and carry into its MSB.
module add_chunk #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_cout,
   output logic             o_cmsb
);

   logic [CHUNK:0] w_total;

   // Full add; carry into the MSB is recovered from the MSB sum bit
   always_comb begin
      w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
      o_sum   = w_total[CHUNK-1:0];
      o_cout  = w_total[CHUNK];
      o_cmsb  = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_total[CHUNK-1];
   end

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, flags on completion.
module add_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   input  logic             sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] respuesta,
   output logic             Z,
   output logic             N,
   output logic             C,
   output logic             V
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   alu_state_t        r_state;
   alu_state_t        w_next;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_res;
   logic [WIDTH-1:0]  w_final;
   logic              r_carry;
   logic              r_sign;
   logic [CW-1:0]     r_cnt;
   logic [NFLAGS-1:0] r_flags;
   logic [CHUNK-1:0]  w_sum;
   logic              w_cout;
   logic              w_cmsb;
   logic              w_last;
   logic              w_accept;

   assign w_last   = (r_cnt == LAST);
   assign w_accept = in_valid && (r_state == IDLE);

   add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a    (r_a[r_cnt*CHUNK +: CHUNK]),
      .i_b    (r_b[r_cnt*CHUNK +: CHUNK]),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
   );

   // Complete result as it will look once the MSB chunk is written
   always_comb begin
      w_final = r_res;
      w_final[WIDTH-1 -: CHUNK] = w_sum;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_next = CALC;
         CALC:    if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default:                w_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // Operand capture, per-chunk accumulation and flag generation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_sign  <= 1'b0;
         r_cnt   <= '0;
         r_flags <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a     <= A;
                  r_b     <= sub ? ~B : B;
                  r_carry <= sub;
                  r_sign  <= sign;
                  r_cnt   <= '0;
               end
            end
            CALC: begin
               r_res[r_cnt*CHUNK +: CHUNK] <= w_sum;
               r_carry <= w_cout;
               if (w_last) begin
                  r_cnt           <= '0;
                  r_flags[FLAG_Z] <= (w_final == '0);
                  r_flags[FLAG_N] <= r_sign & w_final[WIDTH-1];
                  r_flags[FLAG_C] <= w_cout;
                  // Signed overflow: carry into MSB differs from carry out
                  r_flags[FLAG_V] <= r_sign & (w_cmsb ^ w_cout);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign respuesta = r_res;
   assign Z = r_flags[FLAG_Z];
   assign N = r_flags[FLAG_N];
   assign C = r_flags[FLAG_C];
   assign V = r_flags[FLAG_V];

endmodule
